// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: operand width, shift types, ALU opcodes,
// the operand-2 pipeline entry and a 32-bit rotate helper.
package arm_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_type_e;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_EOR = 4'b0001,
      ALU_SUB = 4'b0010,
      ALU_RSB = 4'b0011,
      ALU_ADD = 4'b0100,
      ALU_ADC = 4'b0101,
      ALU_SBC = 4'b0110,
      ALU_RSC = 4'b0111,
      ALU_TST = 4'b1000,
      ALU_TEQ = 4'b1001,
      ALU_CMP = 4'b1010,
      ALU_CMN = 4'b1011,
      ALU_ORR = 4'b1100,
      ALU_MOV = 4'b1101,
      ALU_BIC = 4'b1110,
      ALU_MVN = 4'b1111
   } alu_op_e;

   typedef struct packed {
      logic [DATA_W-1:0] source_1;
      logic [DATA_W-1:0] source_2;
      logic [3:0]        alu_op;
      logic              c_in;
      logic              shift_c;
   } op2_entry_t;

   // A zero amount yields v unchanged because v << 32 vanishes in 32 bits.
   function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] v,
                                               input logic [4:0]        amt);
      return (v >> amt) | (v << (6'(DATA_W) - {1'b0, amt}));
   endfunction

endpackage

// File: rtl/op2_shift_stage_if.sv
// Operand-2 stage bus: upstream decode/register-read side, downstream ALU
// side and the branch-redirect flush.
interface op2_shift_stage_if;
   import arm_pkg::*;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] rn_data;
   logic [DATA_W-1:0] rm_data;
   logic [7:0]        rs_amt;
   logic [4:0]        imm_amt;
   logic [1:0]        shift_type;
   logic              shift_by_reg;
   logic              op2_imm;
   logic [11:0]       imm12;
   logic [3:0]        alu_op_in;
   logic              c_flag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] source_1;
   logic [DATA_W-1:0] source_2;
   logic [3:0]        alu_op;
   logic              c_in;
   logic              shift_c;

   modport slave (
      input  flush, in_valid, rn_data, rm_data, rs_amt, imm_amt, shift_type,
             shift_by_reg, op2_imm, imm12, alu_op_in, c_flag, out_ready,
      output in_ready, out_valid, source_1, source_2, alu_op, c_in, shift_c
   );

   modport master (
      output flush, in_valid, rn_data, rm_data, rs_amt, imm_amt, shift_type,
             shift_by_reg, op2_imm, imm12, alu_op_in, c_flag, out_ready,
      input  in_ready, out_valid, source_1, source_2, alu_op, c_in, shift_c
   );

endinterface

// File: rtl/op2_shift_stage_barrel_shift.sv
// Combinational ARM barrel shifter covering immediate-amount encodings
// (LSR/ASR #0 mean 32, ROR #0 is RRX) and register-amount semantics.
module barrel_shift
   import arm_pkg::*;
(
   input  logic [DATA_W-1:0] value,
   input  logic [7:0]        amount,
   input  logic [1:0]        shift_type,
   input  logic              by_reg,
   input  logic              c_flag,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [4:0] n;
   logic [4:0] lsl_idx;
   logic [4:0] rsh_idx;
   logic       ge32;
   logic       eq32;

   // Carry-out bit positions: Rm[32-n] for left shifts, Rm[n-1] for right.
   assign n       = amount[4:0];
   assign lsl_idx = 5'd0 - n;
   assign rsh_idx = n - 5'd1;
   assign ge32    = |amount[7:5];
   assign eq32    = (amount == 8'd32);

   always_comb begin
      result = value;
      carry  = c_flag;
      if (!by_reg) begin
         case (shift_type)
            SH_LSL: begin
               if (n != 5'd0) begin
                  result = value << n;
                  carry  = value[lsl_idx];
               end
            end
            SH_LSR: begin
               if (n == 5'd0) begin
                  result = '0;
                  carry  = value[DATA_W-1];
               end else begin
                  result = value >> n;
                  carry  = value[rsh_idx];
               end
            end
            SH_ASR: begin
               if (n == 5'd0) begin
                  result = {DATA_W{value[DATA_W-1]}};
                  carry  = value[DATA_W-1];
               end else begin
                  result = DATA_W'($signed(value) >>> n);
                  carry  = value[rsh_idx];
               end
            end
            default: begin
               if (n == 5'd0) begin
                  result = {c_flag, value[DATA_W-1:1]};
                  carry  = value[0];
               end else begin
                  result = ror32(value, n);
                  carry  = value[rsh_idx];
               end
            end
         endcase
      end else if (amount != 8'd0) begin
         case (shift_type)
            SH_LSL: begin
               if (!ge32) begin
                  result = value << n;
                  carry  = value[lsl_idx];
               end else begin
                  result = '0;
                  carry  = eq32 ? value[0] : 1'b0;
               end
            end
            SH_LSR: begin
               if (!ge32) begin
                  result = value >> n;
                  carry  = value[rsh_idx];
               end else begin
                  result = '0;
                  carry  = eq32 ? value[DATA_W-1] : 1'b0;
               end
            end
            SH_ASR: begin
               if (!ge32) begin
                  result = DATA_W'($signed(value) >>> n);
                  carry  = value[rsh_idx];
               end else begin
                  result = {DATA_W{value[DATA_W-1]}};
                  carry  = value[DATA_W-1];
               end
            end
            default: begin
               // Register rotates wrap modulo 32; a multiple of 32 leaves Rm intact.
               if (n == 5'd0) begin
                  carry = value[DATA_W-1];
               end else begin
                  result = ror32(value, n);
                  carry  = value[rsh_idx];
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/op2_shift_stage.sv
// Registered operand-2 stage feeding the ALU. Defining OP2_SKID_EN adds a
// one-entry skid buffer and makes in_ready a registered signal.
module op2_shift_stage
   import arm_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 8
) (
   input logic               clk,
   input logic               rst_n,
   op2_shift_stage_if.slave  bus
);

   logic [AMT_W-1:0]  amount;
   logic [DATA_W-1:0] shift_res;
   logic              shift_carry;
   logic [DATA_W-1:0] imm_res;
   logic              imm_carry;
   op2_entry_t        new_entry;
   op2_entry_t        out_q;
   logic              out_valid_q;
   logic              in_ready_int;
   logic              in_fire;

   assign amount = bus.shift_by_reg ? bus.rs_amt : AMT_W'(bus.imm_amt);

   barrel_shift u_shift (
      .value      (bus.rm_data),
      .amount     (amount),
      .shift_type (bus.shift_type),
      .by_reg     (bus.shift_by_reg),
      .c_flag     (bus.c_flag),
      .result     (shift_res),
      .carry      (shift_carry)
   );

   // Rotated immediate: imm8 ROR (2*rot4); carry only changes when rotated.
   assign imm_res   = ror32({{(DATA_W-8){1'b0}}, bus.imm12[7:0]}, {bus.imm12[11:8], 1'b0});
   assign imm_carry = (bus.imm12[11:8] == 4'd0) ? bus.c_flag : imm_res[DATA_W-1];

   always_comb begin
      new_entry          = '0;
      new_entry.source_1 = bus.rn_data;
      new_entry.source_2 = bus.op2_imm ? imm_res : shift_res;
      new_entry.alu_op   = bus.alu_op_in;
      new_entry.c_in     = bus.c_flag;
      new_entry.shift_c  = bus.op2_imm ? imm_carry : shift_carry;
   end

   assign in_fire = bus.in_valid & in_ready_int;

`ifdef OP2_SKID_EN
   op2_entry_t skid_q;
   logic       skid_valid_q;
   logic       out_free;

   assign out_free     = ~out_valid_q | bus.out_ready;
   assign in_ready_int = ~skid_valid_q;

   // The skid entry is always older than anything arriving, so it drains first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
      end else if (bus.flush) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else if (in_fire) begin
            out_q       <= new_entry;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (in_fire) begin
         skid_q       <= new_entry;
         skid_valid_q <= 1'b1;
      end
   end
`else
   assign in_ready_int = ~out_valid_q | bus.out_ready;

   // A load in the same cycle as a consume keeps out_valid high for full rate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (in_fire) begin
         out_q       <= new_entry;
         out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_q;
   assign bus.source_1  = out_q.source_1;
   assign bus.source_2  = out_q.source_2;
   assign bus.alu_op    = out_q.alu_op;
   assign bus.c_in      = out_q.c_in;
   assign bus.shift_c   = out_q.shift_c;

endmodule

// File: doc/op2_shift_stage.md
Name: op2_shift_stage

Overview:
- Pipelined operand-2 stage directly upstream of the ALU.
- Takes register-read data and the decoded shifter controls, and forms source_1, source_2 and c_in for the ALU, plus the shifter carry-out for logical-op C flags.
- One registered stage with a valid/ready handshake toward the ALU/execute stage, plus a synchronous flush for branch redirect.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- AMT_W, 8, width of the register-specified shift amount (Rs[7:0]).

Ports:
- clk  in  1  clock; all state is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- rn_data  in  32  first operand, passed through as source_1.
- rm_data  in  32  register operand to be shifted.
- rs_amt  in  8  register shift amount.
- imm_amt  in  5  immediate shift amount.
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX.
- shift_by_reg  in  1  use rs_amt instead of imm_amt.
- op2_imm  in  1  operand 2 is a rotated immediate.
- imm12  in  12  {rot4, imm8}.
- alu_op_in  in  4  ALU opcode, passed through.
- c_flag  in  1  current CPSR C.
- out_valid  out  1  registered outputs are valid.
- out_ready  in  1  ALU stage consumes this cycle.
- source_1  out  32  registered rn_data.
- source_2  out  32  registered shifter result.
- alu_op  out  4  registered alu_op_in.
- c_in  out  1  registered c_flag; carry input for ADC/SBC/RSC.
- shift_c  out  1  registered shifter carry-out.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0; source_1, source_2, alu_op, c_in and shift_c all 0; skid empty.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Latency is 1 cycle from input transfer to out_valid.
- in_ready = ~out_valid | out_ready, combinational (base build). in_ready is 1 out of reset.
- Stall: while out_valid & ~out_ready, all outputs are held stable.
- Simultaneous output and input transfer: the register reloads and out_valid stays 1, giving full throughput.
- Flush:
  - Next edge: out_valid=0 and skid empty. The input offered in the flush cycle is dropped.
  - Flush has priority over load.
  - Data registers may keep stale values.
- Immediate path (op2_imm=1): result = imm8 ROR (2*rot4). shift_c = c_flag if rot4==0, else result[31].
- Immediate-amount shifts (shift_by_reg=0), n = imm_amt:
  - LSL: n=0 gives Rm with carry C; else Rm<<n with carry Rm[32-n].
  - LSR: n=0 means 32, giving 0 with carry Rm[31]; else Rm>>n with carry Rm[n-1].
  - ASR: n=0 means 32, giving {32{Rm[31]}} with carry Rm[31]; else arithmetic shift with carry Rm[n-1].
  - ROR: n=0 is RRX, giving {C, Rm[31:1]} with carry Rm[0]; else rotate with carry Rm[n-1].
- Register-amount shifts (shift_by_reg=1), a = rs_amt:
  - a=0, any type: Rm with carry C.
  - LSL: a<32 gives Rm<<a with carry Rm[32-a]; a=32 gives 0 with carry Rm[0]; a>32 gives 0 with carry 0.
  - LSR: a<32 gives Rm>>a with carry Rm[a-1]; a=32 gives 0 with carry Rm[31]; a>32 gives 0 with carry 0.
  - ASR: a>=32 gives {32{Rm[31]}} with carry Rm[31].
  - ROR: a[4:0]==0 (a nonzero) gives Rm with carry Rm[31]; else rotate by a[4:0] with carry Rm[a[4:0]-1].
- All shift arithmetic is done on the input side, before the register. No multi-cycle paths.

Optional Feature:
- Macro: OP2_SKID_EN.
- Defined:
  - A 1-entry skid buffer is added and in_ready becomes a registered signal, equal to skid empty.
  - On stall with an input transfer, the entry goes into the skid. The skid drains to the output register on the next output transfer.
  - Order is preserved; maximum occupancy is 2.
  - Flush clears both entries.
  - Reset sets in_ready=1.
- Undefined: the combinational in_ready described under Behaviour.

Decomposition:
- Shared package arm_pkg:
  - Shift-type constants SH_LSL, SH_LSR, SH_ASR, SH_ROR.
  - DATA_W and the ALU opcode constants (AND=0000 … MVN=1111), reused by decode and the ALU.
- Sub-module barrel_shift: purely combinational. Inputs are value, amount, type, imm/reg mode and c_flag; outputs are result and carry. It is tested standalone.

Test Plan:
- LSL imm: rm=0x8000_0001, imm_amt=1 -> source_2=0x0000_0002, shift_c=1, out_valid one cycle after the transfer.
- Imm encodings: imm12=0x4FF -> source_2=0xFF00_0000, shift_c=1. imm12=0x0FF with c_flag=0 -> 0x0000_00FF, shift_c=0.
- Reg-shift boundaries on rm=0x8000_0001:
  - LSR a=32 -> 0, c=1.
  - LSL a=33 -> 0, c=0.
  - ASR a=200 -> 0xFFFF_FFFF, c=1.
  - ROR a=32 -> 0x8000_0001, c=1.
- RRX: rm=0x0000_0003, ROR imm_amt=0, c_flag=1 -> 0x8000_0001, shift_c=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable; in_ready=0 (base) or the skid fills then in_ready=0 (OP2_SKID_EN). Release -> entries emerge in order with no loss or duplication.
- Flush and reset: flush during a stall -> out_valid=0 next cycle and the flush-cycle input is dropped. Assert rst_n=0 mid-stream -> out_valid=0 immediately and all outputs 0.
